// File: rtl/spi_target_port_pkg.sv
// Shared definitions for the SPI target port: FSM encoding and word geometry.
package spi_target_port_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  localparam int WORD_BITS = 32;
  localparam int BYTE_BITS = 8;
  localparam logic [WORD_BITS-1:0] IDLE_FILL_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/spi_target_port_if.sv
// Bus-side word handshakes of the SPI target port (TX holding register, RX word, status pulses).
interface spi_target_port_if;
  import spi_target_port_pkg::*;

  logic [WORD_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic [WORD_BITS-1:0] rx_data_o;
  logic [2:0]           rx_bytes_o;
  logic                 rx_valid_o;
  logic                 rx_ack_i;
  logic                 rx_overrun_o;
  logic                 tx_underrun_o;
  logic                 frame_err_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ack_i,
    output tx_ready_o, rx_data_o, rx_bytes_o, rx_valid_o,
           rx_overrun_o, tx_underrun_o, frame_err_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ack_i,
    input  tx_ready_o, rx_data_o, rx_bytes_o, rx_valid_o,
           rx_overrun_o, tx_underrun_o, frame_err_o
  );

endinterface

// File: rtl/spi_target_port_input_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detection
// on the last two synchronised samples. Resets to 0 so a select line that is
// already low at reset release never looks like a fresh idle level.
module spi_target_port_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target_port.sv
// SPI target (slave) port: oversamples SPI pins in HCLK, assembles 32-bit RX words
// (flushing whole trailing bytes at deselect) and shifts 32-bit TX words out on MISO.
module spi_target_port
  import spi_target_port_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [WORD_BITS-1:0] IDLE_FILL   = IDLE_FILL_DEFAULT
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic cpol_i,
  input  logic cpha_i,
  input  logic spi_clk_i,
  input  logic spi_ss_n_i,
  input  logic spi_mosi_i,
  output logic spi_miso_o,
  output logic spi_miso_oe_o,
  spi_target_port_if.slave bus
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_target_port_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(HCLK), .rst_n(HRESETn), .async_in(spi_clk_i),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_target_port_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(HCLK), .rst_n(HRESETn), .async_in(spi_ss_n_i),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_target_port_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(HCLK), .rst_n(HRESETn), .async_in(spi_mosi_i),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t               state_q, state_d;
  logic                 cpol_q, cpha_q;
  logic [4:0]           bit_cnt;
  logic [WORD_BITS-1:0] rx_shift, rx_data, rx_word_next;
  logic [2:0]           rx_bytes;
  logic                 rx_valid, rx_overrun, frame_err;
  logic [WORD_BITS-1:0] tx_hold, tx_shift, tx_next_word;
  logic                 tx_hold_full, tx_underrun, miso_q;

  logic enter_active, leave_active, in_frame;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic word_done, flush_req, deliver, tx_load, tx_accept, stray_bits;

  // Whole bytes received before deselect, right-justified; stray low bits dropped.
  function automatic logic [WORD_BITS-1:0] flush_word(input logic [WORD_BITS-1:0] shift,
                                                      input logic [4:0]           cnt);
    logic [WORD_BITS-1:0] aligned, mask;
    aligned = shift >> cnt[2:0];
    mask    = ~({WORD_BITS{1'b1}} << (int'(cnt[4:3]) * BYTE_BITS));
    return aligned & mask;
  endfunction

  assign enter_active = (state_q == ST_IDLE) && ss_fall;
  assign leave_active = (state_q == ST_ACTIVE) && ss_rise;
  assign in_frame     = (state_q == ST_ACTIVE) && !ss_rise;

  // Leading edge moves the clock away from its idle level.
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge && (sclk_level != cpol_q);
  assign trail_edge  = sclk_edge && (sclk_level == cpol_q);
  assign sample_edge = in_frame && (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = in_frame && (cpha_q ? lead_edge : trail_edge);

  assign rx_word_next = {rx_shift[WORD_BITS-2:0], mosi_level};
  assign word_done    = sample_edge && (bit_cnt == 5'd31);
  assign stray_bits   = |bit_cnt[2:0];
  assign flush_req    = leave_active && (bit_cnt[4:3] != 2'd0);
  assign deliver      = word_done || flush_req;

  assign tx_load      = enter_active || word_done;
  assign tx_accept    = bus.tx_valid_i && !tx_hold_full;
  assign tx_next_word = tx_hold_full ? tx_hold : IDLE_FILL;

  // FSM state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_q <= ST_DISARMED;
    else          state_q <= state_d;
  end

  // FSM next state: only arm once select is seen high, so no frame is joined mid-way
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISARMED: if (ss_level) state_d = ST_IDLE;
      ST_IDLE:     if (ss_fall)  state_d = ST_ACTIVE;
      ST_ACTIVE:   if (ss_rise)  state_d = ST_IDLE;
      default:                   state_d = ST_DISARMED;
    endcase
  end

  // FSM outputs: MISO driven only while selected
  always_comb begin
    spi_miso_oe_o = (state_q == ST_ACTIVE);
  end

  // Receive path: mode latch, bit counter, word assembly, delivery and status pulses
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      bit_cnt    <= 5'd0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_bytes   <= 3'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      if (enter_active) begin
        cpol_q  <= cpol_i;
        cpha_q  <= cpha_i;
        bit_cnt <= 5'd0;
      end
      if (sample_edge) begin
        rx_shift <= rx_word_next;
        bit_cnt  <= bit_cnt + 5'd1;
      end
      if (leave_active) begin
        bit_cnt   <= 5'd0;
        frame_err <= stray_bits;
      end
      if (deliver) begin
        rx_data    <= word_done ? rx_word_next : flush_word(rx_shift, bit_cnt);
        rx_bytes   <= word_done ? 3'd4 : {1'b0, bit_cnt[4:3]};
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !bus.rx_ack_i;
      end else if (bus.rx_ack_i) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit path: holding register, word loads and MISO shifting.
  // tx_shift holds bits not yet driven; with cpha=0 bit 31 is driven at select.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      tx_hold      <= '0;
      tx_hold_full <= 1'b0;
      tx_shift     <= '0;
      tx_underrun  <= 1'b0;
      miso_q       <= 1'b1;
    end else begin
      tx_underrun <= 1'b0;
      if (tx_accept) begin
        tx_hold      <= bus.tx_data_i;
        tx_hold_full <= 1'b1;
      end
      if (tx_load) begin
        if (tx_hold_full) tx_hold_full <= 1'b0;
        else              tx_underrun  <= 1'b1;
        if (enter_active && !cpha_i) begin
          miso_q   <= tx_next_word[WORD_BITS-1];
          tx_shift <= {tx_next_word[WORD_BITS-2:0], 1'b0};
        end else begin
          tx_shift <= tx_next_word;
        end
      end else if (shift_edge) begin
        miso_q   <= tx_shift[WORD_BITS-1];
        tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
      end
      if (leave_active) miso_q <= 1'b1;
    end
  end

  assign spi_miso_o        = miso_q;
  assign bus.tx_ready_o    = ~tx_hold_full;
  assign bus.rx_data_o     = rx_data;
  assign bus.rx_bytes_o    = rx_bytes;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.rx_overrun_o  = rx_overrun;
  assign bus.tx_underrun_o = tx_underrun;
  assign bus.frame_err_o   = frame_err;

endmodule

// File: tb/tb_spi_target_port.sv
// Bench for spi_target_port: an SPI master drives framed transfers at HCLK/8 and a
// frame-level reference model predicts RX words, MISO stream and status pulses.
module tb_spi_target_port;

  localparam int          HALF = 4;
  localparam logic [31:0] FILL = 32'hFFFF_FFFF;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic cpol_i, cpha_i, spi_clk_i, spi_ss_n_i, spi_mosi_i;
  logic spi_miso_o, spi_miso_oe_o;

  spi_target_port_if bus ();

  spi_target_port dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .spi_clk_i(spi_clk_i), .spi_ss_n_i(spi_ss_n_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  int vectors = 0;
  int miscompares = 0;
  int n_ovr = 0, n_und = 0, n_ferr = 0;

  always @(negedge HCLK) begin
    if (bus.rx_overrun_o === 1'b1)  n_ovr++;
    if (bus.tx_underrun_o === 1'b1) n_und++;
    if (bus.frame_err_o === 1'b1)   n_ferr++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [31:0] w);
    int waited = 0;
    @(negedge HCLK);
    while (bus.tx_ready_o !== 1'b1 && waited < 50) begin
      @(negedge HCLK);
      waited++;
    end
    check("tx_ready_wait", bus.tx_ready_o, 1);
    bus.tx_data_i  = w;
    bus.tx_valid_i = 1'b1;
    @(negedge HCLK);
    bus.tx_valid_i = 1'b0;
    check("tx_ready_drop", bus.tx_ready_o, 0);
  endtask

  // SPI master: nbits of mosi_word (MSB first) out, MISO bits captured right-justified.
  task automatic spi_frame(input int mode, input int nbits, input logic [63:0] mosi_word,
                           input int rst_at, output logic [63:0] miso_word, output int oe_on);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    miso_word = '0;
    oe_on = 0;
    @(negedge HCLK);
    cpol_i = cpol;
    cpha_i = cpha;
    spi_clk_i = cpol;
    repeat (4) @(negedge HCLK);
    if (!cpha) spi_mosi_i = mosi_word[nbits-1];
    spi_ss_n_i = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      repeat (HALF) @(negedge HCLK);
      if (i == rst_at) begin
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
      end
      if (i >= rst_at && spi_miso_oe_o === 1'b1) oe_on++;
      if (cpha) spi_mosi_i = mosi_word[nbits-1-i];
      else      miso_word = {miso_word[62:0], spi_miso_o};
      spi_clk_i = ~cpol;
      repeat (HALF) @(negedge HCLK);
      if (cpha) miso_word = {miso_word[62:0], spi_miso_o};
      spi_clk_i = cpol;
      if (!cpha && i < nbits - 1) spi_mosi_i = mosi_word[nbits-2-i];
    end
    repeat (HALF) @(negedge HCLK);
    spi_ss_n_i = 1'b1;
    repeat (8) @(negedge HCLK);
  endtask

  task automatic ack_rx();
    @(negedge HCLK);
    bus.rx_ack_i = 1'b1;
    @(negedge HCLK);
    bus.rx_ack_i = 1'b0;
    check("rx_valid_after_ack", bus.rx_valid_o, 0);
  endtask

  // One frame checked against the frame-level model.
  task automatic run_check(input int mode, input int nbits, input logic [63:0] data,
                           input bit tx_present, input logic [31:0] tx_word);
    int full, rem, nbytes, stray, deliv, loads, oe_on;
    int ovr0, und0, ferr0;
    logic [63:0] exp_rx, stream, exp_miso, miso;
    full   = nbits / 32;
    rem    = nbits % 32;
    nbytes = rem / 8;
    stray  = rem % 8;
    deliv  = full + ((nbytes > 0) ? 1 : 0);
    if (nbytes > 0) exp_rx = (data >> stray) & ((64'd1 << (nbytes * 8)) - 64'd1);
    else            exp_rx = (data >> rem) & 64'hFFFF_FFFF;
    loads    = 1 + full;
    stream   = {(tx_present ? tx_word : FILL), FILL};
    exp_miso = stream >> (64 - nbits);

    if (tx_present) push_tx(tx_word);
    ovr0 = n_ovr; und0 = n_und; ferr0 = n_ferr;
    spi_frame(mode, nbits, data, -1, miso, oe_on);

    check("rx_valid", bus.rx_valid_o, (deliv > 0) ? 1 : 0);
    if (deliv > 0) begin
      check("rx_data", bus.rx_data_o, exp_rx);
      check("rx_bytes", bus.rx_bytes_o, (nbytes > 0) ? nbytes : 4);
    end
    check("rx_overrun_pulses", n_ovr - ovr0, (deliv > 0) ? deliv - 1 : 0);
    check("tx_underrun_pulses", n_und - und0, loads - (tx_present ? 1 : 0));
    check("frame_err_pulses", n_ferr - ferr0, (stray != 0) ? 1 : 0);
    check("miso_bits", miso, exp_miso);
    check("miso_oe_in_frame", oe_on, nbits);
    check("miso_oe_idle", spi_miso_oe_o, 0);
    check("tx_ready_idle", bus.tx_ready_o, 1);
    if (bus.rx_valid_o === 1'b1) ack_rx();
  endtask

  initial begin
    logic [63:0] miso;
    int oe_on;
    HRESETn = 1'b0;
    cpol_i = 1'b0; cpha_i = 1'b0;
    spi_clk_i = 1'b0; spi_ss_n_i = 1'b1; spi_mosi_i = 1'b0;
    bus.tx_data_i = '0; bus.tx_valid_i = 1'b0; bus.rx_ack_i = 1'b0;
    repeat (5) @(negedge HCLK);

    check("rst_miso", spi_miso_o, 1);
    check("rst_oe", spi_miso_oe_o, 0);
    check("rst_tx_ready", bus.tx_ready_o, 1);
    check("rst_rx_valid", bus.rx_valid_o, 0);
    check("rst_rx_data", bus.rx_data_o, 0);
    check("rst_rx_bytes", bus.rx_bytes_o, 0);
    check("rst_overrun", bus.rx_overrun_o, 0);
    check("rst_underrun", bus.tx_underrun_o, 0);
    check("rst_frame_err", bus.frame_err_o, 0);

    HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);

    for (int m = 0; m < 4; m++) run_check(m, 32, 64'hA5C3_0F81, 1'b1, 32'h1234_5678);

    run_check(0, 16, 64'hBEEF, 1'b1, $urandom);
    run_check(1, 11, {$urandom, $urandom}, 1'b0, 32'h0);
    run_check(2, 64, {32'hDEAD_BEEF, 32'h0BAD_F00D}, 1'b0, 32'h0);

    // Reset pulse while selected: port must stay off the bus until select cycles.
    spi_frame(3, 32, {$urandom, $urandom}, 10, miso, oe_on);
    check("rstmid_oe", oe_on, 0);
    check("rstmid_rx_valid", bus.rx_valid_o, 0);
    check("rstmid_tx_ready", bus.tx_ready_o, 1);
    check("rstmid_miso", spi_miso_o, 1);
    run_check(3, 32, {$urandom, $urandom}, 1'b1, $urandom);

    for (int k = 0; k < 8; k++) begin
      run_check($urandom_range(0, 3), $urandom_range(1, 64), {$urandom, $urandom},
                1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
